// File: rtl/vx_amo_rmw_ctrl_pkg.sv
// Shared opcodes, FSM state type and opcode legality helper for the AMO read-modify-write controller.
package vx_amo_rmw_ctrl_pkg;

  localparam int INST_AMO_BITS = 5;

  localparam logic [INST_AMO_BITS-1:0] INST_AMO_ADD  = 5'h00;
  localparam logic [INST_AMO_BITS-1:0] INST_AMO_SWAP = 5'h01;
  localparam logic [INST_AMO_BITS-1:0] INST_AMO_XOR  = 5'h04;
  localparam logic [INST_AMO_BITS-1:0] INST_AMO_OR   = 5'h08;
  localparam logic [INST_AMO_BITS-1:0] INST_AMO_AND  = 5'h0C;
  localparam logic [INST_AMO_BITS-1:0] INST_AMO_MIN  = 5'h10;
  localparam logic [INST_AMO_BITS-1:0] INST_AMO_MAX  = 5'h14;
  localparam logic [INST_AMO_BITS-1:0] INST_AMO_MINU = 5'h18;
  localparam logic [INST_AMO_BITS-1:0] INST_AMO_MAXU = 5'h1C;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_ALU,
    ST_WR_REQ,
    ST_RSP
  } amo_state_e;

  // LR/SC and unassigned encodings are not handled by this sequencer
  function automatic logic amo_op_legal(input logic [INST_AMO_BITS-1:0] op);
    logic legal;
    case (op)
      INST_AMO_ADD, INST_AMO_SWAP, INST_AMO_XOR, INST_AMO_OR, INST_AMO_AND,
      INST_AMO_MIN, INST_AMO_MAX, INST_AMO_MINU, INST_AMO_MAXU: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/vx_amo_rmw_ctrl_alu.sv
// AMO ALU: combines the old memory word (in1) with rs2 (in2) and registers the result when enabled.
module vx_amo_rmw_ctrl_alu
  import vx_amo_rmw_ctrl_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [INST_AMO_BITS-1:0] op,
  input  logic [31:0]              in1,
  input  logic [31:0]              in2,
  output logic [31:0]              result
);

  logic [31:0] result_d;
  logic        signed_lt;
  logic        unsigned_lt;

  always_comb begin
    signed_lt   = $signed(in1) < $signed(in2);
    unsigned_lt = in1 < in2;
    result_d    = in1 + in2;
    case (op)
      INST_AMO_SWAP: result_d = in2;
      INST_AMO_XOR:  result_d = in1 ^ in2;
      INST_AMO_OR:   result_d = in1 | in2;
      INST_AMO_AND:  result_d = in1 & in2;
      INST_AMO_MIN:  result_d = signed_lt   ? in1 : in2;
      INST_AMO_MAX:  result_d = signed_lt   ? in2 : in1;
      INST_AMO_MINU: result_d = unsigned_lt ? in1 : in2;
      INST_AMO_MAXU: result_d = unsigned_lt ? in2 : in1;
      default:       result_d = in1 + in2;
    endcase
  end

  // Synchronous reset: the result is only consumed in WR_REQ, which a reset always leaves
  always_ff @(posedge clk) begin
    if (reset) begin
      result <= '0;
    end else if (enable) begin
      result <= result_d;
    end
  end

endmodule

// File: rtl/vx_amo_rmw_ctrl.sv
// Serializes atomic read-modify-write operations: read old word, compute via the AMO ALU, write back, return old value.
module vx_amo_rmw_ctrl
  import vx_amo_rmw_ctrl_pkg::*;
#(
  parameter int TAG_WIDTH  = 8,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [INST_AMO_BITS-1:0] req_op,
  input  logic [ADDR_WIDTH-1:0]    req_addr,
  input  logic [31:0]              req_data,
  input  logic [TAG_WIDTH-1:0]     req_tag,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic                     mem_req_rw,
  output logic [ADDR_WIDTH-1:0]    mem_req_addr,
  output logic [31:0]              mem_req_data,
  input  logic                     mem_rsp_valid,
  input  logic [31:0]              mem_rsp_data,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [31:0]              rsp_data,
  output logic [TAG_WIDTH-1:0]     rsp_tag,
  output logic                     rsp_err,
  output logic                     busy
);

  amo_state_e state;
  amo_state_e state_n;

  logic [INST_AMO_BITS-1:0] op_q;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic [31:0]              data_q;
  logic [31:0]              old_q;
  logic [TAG_WIDTH-1:0]     tag_q;
  logic                     err_q;
  logic                     req_fire;
  logic                     req_bad;
  logic                     alu_en;
  logic [31:0]              alu_result;

  assign req_fire = req_valid && req_ready;
  assign req_bad  = (req_addr[1:0] != 2'b00) || !amo_op_legal(req_op);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // old_q is cleared on accept so an erroring request returns zero data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q   <= '0;
      addr_q <= '0;
      data_q <= '0;
      tag_q  <= '0;
      err_q  <= 1'b0;
      old_q  <= '0;
    end else begin
      if (req_fire) begin
        op_q   <= req_op;
        addr_q <= req_addr;
        data_q <= req_data;
        tag_q  <= req_tag;
        err_q  <= req_bad;
        old_q  <= '0;
      end
      if (state == ST_RD_WAIT && mem_rsp_valid) begin
        old_q <= mem_rsp_data;
      end
    end
  end

  always_comb begin
    state_n       = state;
    req_ready     = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_rw    = 1'b0;
    rsp_valid     = 1'b0;
    alu_en        = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_n = req_bad ? ST_RSP : ST_RD_REQ;
        end
      end
      ST_RD_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_n = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (mem_rsp_valid) state_n = ST_ALU;
      end
      ST_ALU: begin
        alu_en  = 1'b1;
        state_n = ST_WR_REQ;
      end
      ST_WR_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b1;
        if (mem_req_ready) state_n = ST_RSP;
      end
      ST_RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  vx_amo_rmw_ctrl_alu u_alu (
    .clk    (clk),
    .reset  (reset),
    .enable (alu_en),
    .op     (op_q),
    .in1    (old_q),
    .in2    (data_q),
    .result (alu_result)
  );

  assign mem_req_addr = addr_q;
  assign mem_req_data = alu_result;
  assign rsp_data     = old_q;
  assign rsp_tag      = tag_q;
  assign rsp_err      = err_q;
  assign busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_vx_amo_rmw_ctrl.sv
// Scoreboard bench for vx_amo_rmw_ctrl: reference memory model, stalling memory slave, response monitor.
module tb_vx_amo_rmw_ctrl;
  import vx_amo_rmw_ctrl_pkg::*;

  localparam int TW = 8;
  localparam int AW = 32;
  localparam logic [4:0] OP_ILLEGAL = 5'h1F;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [4:0]    req_op;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_data;
  logic [TW-1:0] req_tag;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic          mem_req_rw;
  logic [AW-1:0] mem_req_addr;
  logic [31:0]   mem_req_data;
  logic          mem_rsp_valid;
  logic [31:0]   mem_rsp_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_data;
  logic [TW-1:0] rsp_tag;
  logic          rsp_err;
  logic          busy;

  vx_amo_rmw_ctrl #(.TAG_WIDTH(TW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_data(req_data), .req_tag(req_tag),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   data;
    logic [TW-1:0] tag;
    logic          err;
    int            acc_cyc;
    int            lat;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  rsp_t        exp_rsp[$];
  logic [31:0] exp_rd[$];
  wr_t         exp_wr[$];
  logic [31:0] mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int reads = 0;
  int writes = 0;
  int mem_stall = 0;
  int rsp_hold = 0;
  int rd_delay = 1;
  bit rand_mode = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got event expected none/timely", name);
  endtask

  // Specification semantics written directly: signed compare via int, unsigned via logic
  function automatic logic [31:0] amoModel(input logic [4:0] op, input logic [31:0] old, input logic [31:0] val);
    int so;
    int sv;
    so = old;
    sv = val;
    case (op)
      INST_AMO_ADD:  return old + val;
      INST_AMO_SWAP: return val;
      INST_AMO_XOR:  return old ^ val;
      INST_AMO_OR:   return old | val;
      INST_AMO_AND:  return old & val;
      INST_AMO_MIN:  return (so < sv) ? old : val;
      INST_AMO_MAX:  return (so > sv) ? old : val;
      INST_AMO_MINU: return (old < val) ? old : val;
      INST_AMO_MAXU: return (old > val) ? old : val;
      default:       return 32'h0;
    endcase
  endfunction

  function automatic bit opLegal(input logic [4:0] op);
    return op inside {INST_AMO_ADD, INST_AMO_SWAP, INST_AMO_XOR, INST_AMO_OR, INST_AMO_AND,
                      INST_AMO_MIN, INST_AMO_MAX, INST_AMO_MINU, INST_AMO_MAXU};
  endfunction

  // Drives one request, and at its handshake pushes the model's expected read, write and response
  task automatic applyStimulus(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] data,
                               input logic [TW-1:0] tag);
    rsp_t        e;
    wr_t         w;
    logic [31:0] old;
    int          n;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_data  = data;
    req_tag   = tag;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 300);
    if (!req_ready) begin
      failNow("req_accept_timeout");
    end else begin
      e.tag     = tag;
      e.acc_cyc = cyc;
      if (addr[1:0] != 2'b00 || !opLegal(op)) begin
        e.err  = 1'b1;
        e.data = 32'h0;
        e.lat  = 1;
      end else begin
        old    = ref_mem.exists(addr) ? ref_mem[addr] : 32'h0;
        e.err  = 1'b0;
        e.data = old;
        e.lat  = (!rand_mode && mem_stall == 0 && rd_delay == 1) ? 5 : 0;
        ref_mem[addr] = amoModel(op, old, data);
        exp_rd.push_back(addr);
        w.addr = addr;
        w.data = ref_mem[addr];
        exp_wr.push_back(w);
      end
      exp_rsp.push_back(e);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_data  = $urandom;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while ((exp_rsp.size() != 0 || busy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) failNow("idle_timeout");
    checkOutput("pending_reads", exp_rd.size(), 0);
    checkOutput("pending_writes", exp_wr.size(), 0);
  endtask

  // Called at a negedge; asserts reset asynchronously a little later
  task automatic resetNow(input string name);
    #2;
    reset = 1'b1;
    #1;
    checkOutput({name, "_req_ready"}, req_ready, 1);
    checkOutput({name, "_mem_req_valid"}, mem_req_valid, 0);
    checkOutput({name, "_rsp_valid"}, rsp_valid, 0);
    checkOutput({name, "_rsp_err"}, rsp_err, 0);
    checkOutput({name, "_rsp_data"}, rsp_data, 0);
    checkOutput({name, "_rsp_tag"}, rsp_tag, 0);
    checkOutput({name, "_busy"}, busy, 0);
    exp_rsp.delete();
    exp_rd.delete();
    exp_wr.delete();
    ref_mem = mem;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    reset = 1'b0;
  endtask

  // Memory slave and response consumer: handshakes seen at negedge, inputs updated just after posedge
  initial begin
    int          wait_cnt;
    int          hold_cnt;
    int          rd_cnt;
    bit          rd_pend;
    logic [31:0] rd_val;
    wr_t         w;
    wait_cnt = 0;
    hold_cnt = 0;
    rd_cnt   = 0;
    rd_pend  = 1'b0;
    rd_val   = 32'h0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = 32'h0;
    rsp_ready     = 1'b1;
    forever begin
      @(negedge clk);
      if (reset) begin
        rd_pend  = 1'b0;
        wait_cnt = 0;
        hold_cnt = 0;
      end else begin
        if (mem_req_valid && mem_req_ready) begin
          wait_cnt = 0;
          if (!mem_req_rw) begin
            reads++;
            if (exp_rd.size() == 0) failNow("unexpected_read");
            else checkOutput("read_addr", mem_req_addr, exp_rd.pop_front());
            rd_val  = mem.exists(mem_req_addr) ? mem[mem_req_addr] : 32'h0;
            rd_pend = 1'b1;
            rd_cnt  = rand_mode ? int'($urandom_range(1, 3)) : rd_delay;
          end else begin
            writes++;
            if (exp_wr.size() == 0) begin
              failNow("unexpected_write");
            end else begin
              w = exp_wr.pop_front();
              checkOutput("write_addr", mem_req_addr, w.addr);
              checkOutput("write_data", mem_req_data, w.data);
            end
            mem[mem_req_addr] = mem_req_data;
          end
        end
        if (rsp_valid && rsp_ready) hold_cnt = 0;
      end
      @(posedge clk);
      #1;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = $urandom;
      if (rd_pend && !reset) begin
        rd_cnt--;
        if (rd_cnt <= 0) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = rd_val;
          rd_pend       = 1'b0;
        end
      end
      if (rand_mode) begin
        mem_req_ready = 1'($urandom_range(0, 1));
        rsp_ready     = 1'($urandom_range(0, 1));
      end else begin
        if (mem_req_valid && wait_cnt < mem_stall) begin
          mem_req_ready = 1'b0;
          wait_cnt++;
        end else begin
          mem_req_ready = 1'b1;
        end
        if (rsp_valid && hold_cnt < rsp_hold) begin
          rsp_ready = 1'b0;
          hold_cnt++;
        end else begin
          rsp_ready = 1'b1;
        end
      end
    end
  end

  // Response monitor: pops the scoreboard on each completion handshake
  initial begin
    bit   in_rsp;
    rsp_t e;
    in_rsp = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_rsp = 1'b0;
      end else if (rsp_valid) begin
        if (!in_rsp) begin
          in_rsp = 1'b1;
          if (exp_rsp.size() == 0) failNow("unexpected_rsp");
          else if (exp_rsp[0].lat != 0)
            checkOutput("rsp_latency", 32'(cyc - exp_rsp[0].acc_cyc), 32'(exp_rsp[0].lat));
        end
        checkOutput("req_ready_while_rsp", req_ready, 0);
        if (rsp_ready) begin
          in_rsp = 1'b0;
          if (exp_rsp.size() != 0) begin
            e = exp_rsp.pop_front();
            checkOutput("rsp_data", rsp_data, e.data);
            checkOutput("rsp_tag", rsp_tag, e.tag);
            checkOutput("rsp_err", rsp_err, e.err);
          end
        end
      end
    end
  end

  // Valid/ready stability: a stalled valid must hold its payload into the next cycle
  initial begin
    logic          pv, pr, prw, qv, qr, qe;
    logic [31:0]   pa, pd, qd;
    logic [TW-1:0] qt;
    pv = 1'b0; pr = 1'b0; prw = 1'b0; pa = '0; pd = '0;
    qv = 1'b0; qr = 1'b0; qe = 1'b0; qd = '0; qt = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (pv && !pr) begin
          checkOutput("mem_valid_hold", mem_req_valid, 1);
          checkOutput("mem_rw_hold", mem_req_rw, prw);
          checkOutput("mem_addr_hold", mem_req_addr, pa);
          if (prw) checkOutput("mem_data_hold", mem_req_data, pd);
        end
        if (qv && !qr) begin
          checkOutput("rsp_valid_hold", rsp_valid, 1);
          checkOutput("rsp_data_hold", rsp_data, qd);
          checkOutput("rsp_tag_hold", rsp_tag, qt);
          checkOutput("rsp_err_hold", rsp_err, qe);
        end
      end
      pv = mem_req_valid && !reset; pr = mem_req_ready; prw = mem_req_rw;
      pa = mem_req_addr; pd = mem_req_data;
      qv = rsp_valid && !reset; qr = rsp_ready; qd = rsp_data; qt = rsp_tag; qe = rsp_err;
    end
  end

  initial begin
    #3000000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [4:0]  ops [11];
    logic [31:0] addr;
    int          r0;
    int          w0;
    int          n;
    ops = '{INST_AMO_ADD, INST_AMO_SWAP, INST_AMO_XOR, INST_AMO_OR, INST_AMO_AND, INST_AMO_MIN,
            INST_AMO_MAX, INST_AMO_MINU, INST_AMO_MAXU, 5'h02, OP_ILLEGAL};
    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = '0;
    req_addr  = '0;
    req_data  = '0;
    req_tag   = '0;
    mem[32'h100] = 32'd5;
    mem[32'h200] = 32'hFFFF_FFFF;
    mem[32'h204] = 32'hFFFF_FFFF;
    mem[32'h400] = $urandom;
    for (int i = 0; i < 4; i++) mem[32'h500 + 32'(4 * i)] = $urandom;
    ref_mem = mem;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_req_ready", req_ready, 1);
    checkOutput("reset_mem_req_valid", mem_req_valid, 0);
    checkOutput("reset_rsp_valid", rsp_valid, 0);
    checkOutput("reset_rsp_err", rsp_err, 0);
    checkOutput("reset_rsp_data", rsp_data, 0);
    checkOutput("reset_rsp_tag", rsp_tag, 0);
    checkOutput("reset_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] AMOADD with zero-wait memory");
    applyStimulus(INST_AMO_ADD, 32'h100, 32'd3, 8'h11);
    waitIdle();
    checkOutput("amoadd_mem", mem[32'h100], 32'd8);

    $display("[TB] MAX vs MAXU");
    applyStimulus(INST_AMO_MAX, 32'h200, 32'd1, 8'h21);
    applyStimulus(INST_AMO_MAXU, 32'h204, 32'd1, 8'h22);
    waitIdle();
    checkOutput("max_mem", mem[32'h200], 32'd1);
    checkOutput("maxu_mem", mem[32'h204], 32'hFFFF_FFFF);

    $display("[TB] backpressure");
    mem_stall = 3;
    rsp_hold  = 2;
    r0 = reads;
    w0 = writes;
    applyStimulus(INST_AMO_XOR, 32'h100, 32'h0000_F0F0, 8'h31);
    waitIdle();
    checkOutput("bp_read_count", 32'(reads - r0), 1);
    checkOutput("bp_write_count", 32'(writes - w0), 1);
    mem_stall = 0;
    rsp_hold  = 0;

    $display("[TB] error requests");
    r0 = reads;
    applyStimulus(INST_AMO_ADD, 32'h102, 32'd7, 8'h41);
    waitIdle();
    applyStimulus(OP_ILLEGAL, 32'h100, 32'd7, 8'h42);
    waitIdle();
    checkOutput("err_no_reads", 32'(reads - r0), 0);

    $display("[TB] reset during RD_WAIT");
    rd_delay = 6;
    r0 = reads;
    w0 = writes;
    applyStimulus(INST_AMO_ADD, 32'h100, 32'd9, 8'h51);
    n = 0;
    while (reads == r0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checkOutput("rdwait_busy", busy, 1);
    resetNow("rst_rdwait");
    rd_delay = 1;
    repeat (10) @(negedge clk);
    checkOutput("rst_rdwait_no_write", 32'(writes - w0), 0);

    $display("[TB] reset during WR_REQ");
    mem_stall = 4;
    w0 = writes;
    applyStimulus(INST_AMO_OR, 32'h100, 32'h8000_0000, 8'h52);
    n = 0;
    while (!(mem_req_valid && mem_req_rw) && n < 60) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reached_wr_req", 32'(mem_req_valid && mem_req_rw), 1);
    resetNow("rst_wrreq");
    mem_stall = 0;
    repeat (10) @(negedge clk);
    checkOutput("rst_wrreq_no_write", 32'(writes - w0), 0);

    $display("[TB] fresh AMOSWAP after reset");
    applyStimulus(INST_AMO_SWAP, 32'h100, 32'hCAFE_0001, 8'h53);
    waitIdle();
    checkOutput("swap_mem", mem[32'h100], 32'hCAFE_0001);

    $display("[TB] back-to-back SWAP/XOR/MIN/AND");
    applyStimulus(INST_AMO_SWAP, 32'h400, $urandom, 8'h61);
    applyStimulus(INST_AMO_XOR, 32'h400, $urandom, 8'h62);
    applyStimulus(INST_AMO_MIN, 32'h400, $urandom, 8'h63);
    applyStimulus(INST_AMO_AND, 32'h400, $urandom, 8'h64);
    waitIdle();
    checkOutput("b2b_final_mem", mem[32'h400], ref_mem[32'h400]);

    $display("[TB] randomized traffic");
    rand_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      addr = 32'h500 + 32'(4 * $urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) addr = addr + 32'd2;
      applyStimulus(ops[$urandom_range(0, 10)], addr, $urandom, TW'(8'h80 + i));
    end
    waitIdle();
    rand_mode = 1'b0;
    for (int i = 0; i < 4; i++)
      checkOutput("rand_final_mem", mem[32'h500 + 32'(4 * i)], ref_mem[32'h500 + 32'(4 * i)]);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
